// File: rtl/pe_tile_engine.sv
`default_nettype none
// ============================================================================
// Module      : pe_tile_engine
// Description : Bit-serial SIMD tile engine. A TILE x TILE array of 1-bit
//               lanes executes logic, add/sub and neighbour-shift operations
//               over multi-plane operands held in a bit-plane register file.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_tile_engine #(
    parameter  int TILE   = 4,
    parameter  int DEPTH  = 64,
    parameter  int MAXLEN = 32,
    localparam int LANES  = TILE * TILE,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [AW-1:0]    cmd_src_a,
    input  logic [AW-1:0]    cmd_src_b,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [5:0]       cmd_len,
    output logic             done,
    output logic             err,
    output logic [LANES-1:0] carry_vec,
    output logic             flag_all,
    output logic             flag_any,
    input  logic             host_we,
    input  logic [AW-1:0]    host_addr,
    input  logic [LANES-1:0] host_wdata,
    output logic [LANES-1:0] host_rdata,
    input  logic [TILE-1:0]  n_in,
    input  logic [TILE-1:0]  s_in,
    input  logic [TILE-1:0]  e_in,
    input  logic [TILE-1:0]  w_in,
    output logic [TILE-1:0]  n_out,
    output logic [TILE-1:0]  s_out,
    output logic [TILE-1:0]  e_out,
    output logic [TILE-1:0]  w_out
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [3:0] c_OP_MOV = 4'd0;
    localparam logic [3:0] c_OP_NOT = 4'd1;
    localparam logic [3:0] c_OP_AND = 4'd2;
    localparam logic [3:0] c_OP_OR  = 4'd3;
    localparam logic [3:0] c_OP_XOR = 4'd4;
    localparam logic [3:0] c_OP_ADD = 4'd5;
    localparam logic [3:0] c_OP_SUB = 4'd6;
    localparam logic [3:0] c_OP_SHN = 4'd7;
    localparam logic [3:0] c_OP_SHS = 4'd8;
    localparam logic [3:0] c_OP_SHE = 4'd9;
    localparam logic [3:0] c_OP_SHW = 4'd10;

    localparam int c_SW = AW + 7;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [3:0]       r_op;
    logic [AW-1:0]    r_src_a;
    logic [AW-1:0]    r_src_b;
    logic [AW-1:0]    r_dst;
    logic [5:0]       r_len;
    logic [5:0]       r_k;
    logic [LANES-1:0] r_carry;
    logic [LANES-1:0] r_carry_vec;
    logic             r_err;
    logic [LANES-1:0] r_mem [DEPTH];

    logic             w_exec;
    logic             w_accept;
    logic             w_cmd_illegal;
    logic             w_cmd_skip;
    logic [5:0]       w_cmd_len_c;
    logic             w_last;
    logic             w_arith;
    logic [AW-1:0]    w_addr_a;
    logic [AW-1:0]    w_addr_b;
    logic [AW-1:0]    w_addr_d;
    logic [LANES-1:0] w_a;
    logic [LANES-1:0] w_b;
    logic [LANES-1:0] w_b_eff;
    logic [LANES-1:0] w_sum;
    logic [LANES-1:0] w_cout;
    logic [LANES-1:0] w_shn;
    logic [LANES-1:0] w_shs;
    logic [LANES-1:0] w_she;
    logic [LANES-1:0] w_shw;
    logic [LANES-1:0] w_result;
    logic [TILE-1:0]  w_a_east;
    logic [TILE-1:0]  w_a_west;

    assign w_accept      = cmd_valid && cmd_ready;
    assign w_cmd_illegal = (cmd_op > c_OP_SHW);
    assign w_cmd_skip    = (cmd_len == 6'd0) || w_cmd_illegal;
    assign w_cmd_len_c   = (cmd_len > 6'(MAXLEN)) ? 6'(MAXLEN) : cmd_len;
    assign w_last        = (r_k == r_len - 6'd1);
    assign w_arith       = (r_op == c_OP_ADD) || (r_op == c_OP_SUB);

    // Plane addresses wrap modulo DEPTH; the sum is widened so any DEPTH works.
    assign w_addr_a = AW'((c_SW'(r_src_a) + c_SW'(r_k)) % c_SW'(DEPTH));
    assign w_addr_b = AW'((c_SW'(r_src_b) + c_SW'(r_k)) % c_SW'(DEPTH));
    assign w_addr_d = AW'((c_SW'(r_dst)   + c_SW'(r_k)) % c_SW'(DEPTH));

    assign w_a        = r_mem[w_addr_a];
    assign w_b        = r_mem[w_addr_b];
    assign host_rdata = r_mem[host_addr];

    // SUB is A + ~B with the carry seeded to 1 at accept.
    assign w_b_eff = (r_op == c_OP_SUB) ? ~w_b : w_b;
    assign w_sum   = w_a ^ w_b_eff ^ r_carry;
    assign w_cout  = (w_a & w_b_eff) | (r_carry & (w_a ^ w_b_eff));

    for (genvar r = 0; r < TILE; r++) begin : g_row
        for (genvar c = 0; c < TILE; c++) begin : g_col
            localparam int c_LANE = r * TILE + c;
            if (r == TILE - 1) begin : g_shn_edge
                assign w_shn[c_LANE] = s_in[c];
            end else begin : g_shn_mid
                assign w_shn[c_LANE] = w_a[c_LANE + TILE];
            end
            if (r == 0) begin : g_shs_edge
                assign w_shs[c_LANE] = n_in[c];
            end else begin : g_shs_mid
                assign w_shs[c_LANE] = w_a[c_LANE - TILE];
            end
            if (c == 0) begin : g_she_edge
                assign w_she[c_LANE] = w_in[r];
            end else begin : g_she_mid
                assign w_she[c_LANE] = w_a[c_LANE - 1];
            end
            if (c == TILE - 1) begin : g_shw_edge
                assign w_shw[c_LANE] = e_in[r];
            end else begin : g_shw_mid
                assign w_shw[c_LANE] = w_a[c_LANE + 1];
            end
        end
        assign w_a_east[r] = w_a[r * TILE + TILE - 1];
        assign w_a_west[r] = w_a[r * TILE];
    end

    always_comb begin
        w_result = w_a;
        case (r_op)
            c_OP_MOV: w_result = w_a;
            c_OP_NOT: w_result = ~w_a;
            c_OP_AND: w_result = w_a & w_b;
            c_OP_OR:  w_result = w_a | w_b;
            c_OP_XOR: w_result = w_a ^ w_b;
            c_OP_ADD: w_result = w_sum;
            c_OP_SUB: w_result = w_sum;
            c_OP_SHN: w_result = w_shn;
            c_OP_SHS: w_result = w_shs;
            c_OP_SHE: w_result = w_she;
            c_OP_SHW: w_result = w_shw;
            default:  w_result = w_a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (cmd_valid) w_next_state = w_cmd_skip ? c_ST_DONE : c_ST_EXEC;
            c_ST_EXEC: if (w_last)    w_next_state = c_ST_DONE;
            c_ST_DONE: w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        done      = 1'b0;
        w_exec    = 1'b0;
        case (r_state)
            c_ST_IDLE: cmd_ready = 1'b1;
            c_ST_EXEC: w_exec    = 1'b1;
            c_ST_DONE: done      = 1'b1;
            default:   ;
        endcase
    end

    // Plane k is read combinationally before dst+k is written, so in-place is exact.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (w_exec) begin
                r_mem[w_addr_d] <= w_result;
            end else if (cmd_ready && host_we) begin
                r_mem[host_addr] <= host_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op        <= 4'd0;
            r_src_a     <= '0;
            r_src_b     <= '0;
            r_dst       <= '0;
            r_len       <= 6'd0;
            r_k         <= 6'd0;
            r_carry     <= '0;
            r_carry_vec <= '0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            r_op    <= cmd_op;
            r_src_a <= cmd_src_a;
            r_src_b <= cmd_src_b;
            r_dst   <= cmd_dst;
            r_len   <= w_cmd_len_c;
            r_k     <= 6'd0;
            r_carry <= (cmd_op == c_OP_SUB) ? '1 : '0;
            if (w_cmd_skip) begin
                r_err <= w_cmd_illegal;
            end
        end else if (w_exec) begin
            r_k <= r_k + 6'd1;
            if (w_arith) begin
                r_carry <= w_cout;
            end
            if (w_last) begin
                r_err <= 1'b0;
                if (w_arith) begin
                    r_carry_vec <= w_cout;
                end
            end
        end
    end

    assign err       = r_err;
    assign carry_vec = r_carry_vec;
    assign flag_all  = &r_carry_vec;
    assign flag_any  = |r_carry_vec;

    assign n_out = (w_exec && r_op == c_OP_SHN) ? w_a[TILE-1:0]       : '0;
    assign s_out = (w_exec && r_op == c_OP_SHS) ? w_a[LANES-1 -: TILE] : '0;
    assign e_out = (w_exec && r_op == c_OP_SHE) ? w_a_east             : '0;
    assign w_out = (w_exec && r_op == c_OP_SHW) ? w_a_west             : '0;

endmodule
`default_nettype wire

// File: tb/tb_pe_tile_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_tile_engine
// Description : Self-checking bench for pe_tile_engine against an
//               operand-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_tile_engine;
    localparam int TILE   = 4;
    localparam int DEPTH  = 64;
    localparam int MAXLEN = 32;
    localparam int LANES  = 16;
    localparam int AW     = 6;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_op = '0;
    logic [AW-1:0]    cmd_src_a = '0, cmd_src_b = '0, cmd_dst = '0;
    logic [5:0]       cmd_len = '0;
    logic             done, err, flag_all, flag_any;
    logic [LANES-1:0] carry_vec;
    logic             host_we = 1'b0;
    logic [AW-1:0]    host_addr = '0;
    logic [LANES-1:0] host_wdata = '0;
    logic [LANES-1:0] host_rdata;
    logic [TILE-1:0]  n_in = '0, s_in = '0, e_in = '0, w_in = '0;
    logic [TILE-1:0]  n_out, s_out, e_out, w_out;

    always #5 clk = ~clk;

    pe_tile_engine #(.TILE(TILE), .DEPTH(DEPTH), .MAXLEN(MAXLEN)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .done(done), .err(err), .carry_vec(carry_vec), .flag_all(flag_all), .flag_any(flag_any),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .n_in(n_in), .s_in(s_in), .e_in(e_in), .w_in(w_in),
        .n_out(n_out), .s_out(s_out), .e_out(e_out), .w_out(w_out)
    );

    logic [LANES-1:0] m_mem [DEPTH];
    logic [LANES-1:0] m_carry;
    int               n_tests = 0;
    int               n_fail  = 0;

    int               exp_lat, obs_lat;
    logic             exp_err, obs_err, obs_all, obs_any;
    logic [LANES-1:0] obs_cv;
    logic [TILE-1:0]  exp_n, exp_s, exp_e, exp_w;
    logic [TILE-1:0]  obs_n, obs_s, obs_e, obs_w;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int addr, input logic [LANES-1:0] data);
        host_we    = 1'b1;
        host_addr  = AW'(addr);
        host_wdata = data;
        tick();
        host_we    = 1'b0;
        m_mem[addr % DEPTH] = data;
    endtask

    task automatic mem_diff(output int nbad, output int first);
        nbad  = 0;
        first = -1;
        for (int i = 0; i < DEPTH; i++) begin
            host_addr = AW'(i);
            #1;
            if (host_rdata !== m_mem[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        tick();
    endtask

    // Operand-level model: lanes are treated as len-bit integers.
    task automatic model_cmd(input int op, input int a, input int b, input int d, input int len_in);
        int len;
        logic [LANES-1:0] res [MAXLEN];
        logic [LANES-1:0] p, p0;
        longint va, vb, rv;
        len = (len_in > MAXLEN) ? MAXLEN : len_in;
        exp_n = '0; exp_s = '0; exp_e = '0; exp_w = '0;
        if (op > 10 || len == 0) begin
            exp_lat = 1;
            exp_err = (op > 10);
            return;
        end
        exp_lat = len + 1;
        exp_err = 1'b0;
        p0 = m_mem[a % DEPTH];
        if (op <= 6) begin
            for (int l = 0; l < LANES; l++) begin
                va = 0;
                vb = 0;
                for (int k = 0; k < len; k++) begin
                    va |= longint'(m_mem[(a + k) % DEPTH][l]) << k;
                    vb |= longint'(m_mem[(b + k) % DEPTH][l]) << k;
                end
                case (op)
                    0: rv = va;
                    1: rv = ~va;
                    2: rv = va & vb;
                    3: rv = va | vb;
                    4: rv = va ^ vb;
                    5: begin rv = va + vb; m_carry[l] = rv[len]; end
                    default: begin rv = va - vb; m_carry[l] = (va >= vb); end
                endcase
                for (int k = 0; k < len; k++) res[k][l] = rv[k];
            end
        end else begin
            for (int k = 0; k < len; k++) begin
                p = m_mem[(a + k) % DEPTH];
                for (int row = 0; row < TILE; row++) begin
                    for (int col = 0; col < TILE; col++) begin
                        case (op)
                            7: if (row == TILE - 1) res[k][row*TILE+col] = s_in[col];
                               else                 res[k][row*TILE+col] = p[(row+1)*TILE+col];
                            8: if (row == 0) res[k][row*TILE+col] = n_in[col];
                               else          res[k][row*TILE+col] = p[(row-1)*TILE+col];
                            9: if (col == 0) res[k][row*TILE+col] = w_in[row];
                               else          res[k][row*TILE+col] = p[row*TILE+col-1];
                            default: if (col == TILE - 1) res[k][row*TILE+col] = e_in[row];
                                     else                 res[k][row*TILE+col] = p[row*TILE+col+1];
                        endcase
                    end
                end
            end
            for (int i = 0; i < TILE; i++) begin
                if (op == 7)  exp_n[i] = p0[i];
                if (op == 8)  exp_s[i] = p0[(TILE-1)*TILE+i];
                if (op == 9)  exp_e[i] = p0[i*TILE+TILE-1];
                if (op == 10) exp_w[i] = p0[i*TILE];
            end
        end
        for (int k = 0; k < len; k++) m_mem[(d + k) % DEPTH] = res[k];
    endtask

    // Issues one command from IDLE and follows it to its done pulse (bounded).
    task automatic issue(input int op, input int a, input int b, input int d, input int len,
                         input bit poke, input int poke_addr);
        cmd_op    = 4'(op);
        cmd_src_a = AW'(a);
        cmd_src_b = AW'(b);
        cmd_dst   = AW'(d);
        cmd_len   = 6'(len);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        obs_n = n_out; obs_s = s_out; obs_e = e_out; obs_w = w_out;
        if (poke) begin
            host_we    = 1'b1;
            host_addr  = AW'(poke_addr);
            host_wdata = ~m_mem[poke_addr];
        end
        obs_lat = -1;
        for (int i = 1; i <= 100; i++) begin
            if (done) begin
                obs_lat = i;
                obs_cv  = carry_vec;
                obs_err = err;
                obs_all = flag_all;
                obs_any = flag_any;
                break;
            end
            tick();
        end
        host_we = 1'b0;
        if (obs_lat >= 0) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        m_carry = '0;
        n_tests++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        n_tests++;
        if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err: got %b/%b want 0/0", done, err); end
        n_tests++;
        if (carry_vec !== 16'h0 || flag_any !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %h want 0000", carry_vec); end
        n_tests++;
        if ({n_out, s_out, e_out, w_out} !== 16'h0) begin
            n_fail++; $display("FAIL reset_edges: got %h want 0000", {n_out, s_out, e_out, w_out});
        end
        tick();
        for (int i = 0; i < DEPTH; i++) host_write(i, 16'($urandom));
    endtask

    task automatic test_add();
        int nb, fa;
        logic [LANES-1:0] pl;
        for (int k = 0; k < 8; k++) begin
            for (int l = 0; l < LANES; l++) pl[l] = 1'((l >> k) & 1);
            host_write(k, pl);
        end
        for (int k = 8; k < 16; k++) host_write(k, (k < 10) ? 16'hFFFF : 16'h0000);
        model_cmd(5, 0, 8, 16, 8);
        issue(5, 0, 8, 16, 8, 1'b0, 0);
        n_tests++;
        if (obs_lat !== 9) begin n_fail++; $display("FAIL add_latency: got %0d want 9", obs_lat); end
        n_tests++;
        if (obs_cv !== 16'h0) begin n_fail++; $display("FAIL add_carry: got %h want 0000", obs_cv); end
        for (int l = 0; l < LANES; l += 5) begin
            int v;
            v = 0;
            for (int k = 0; k < 8; k++) begin
                host_addr = AW'(16 + k);
                #1;
                v |= int'(host_rdata[l]) << k;
            end
            n_tests++;
            if (v !== l + 3) begin n_fail++; $display("FAIL add_lane%0d: got %0d want %0d", l, v, l + 3); end
        end
        tick();
        mem_diff(nb, fa);
        n_tests++;
        if (nb !== 0) begin n_fail++; $display("FAIL add_mem: %0d planes differ (first %0d), want 0", nb, fa); end
    endtask

    task automatic test_sub();
        logic [LANES-1:0] e1 [4];
        logic [LANES-1:0] e2 [4];
        e1 = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        e2 = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        host_write(24, 16'hFFFF); host_write(25, 16'h0000);
        host_write(26, 16'hFFFF); host_write(27, 16'h0000);
        host_write(28, 16'hFFFF); host_write(29, 16'hFFFF);
        host_write(30, 16'hFFFF); host_write(31, 16'h0000);
        model_cmd(6, 24, 28, 32, 4);
        issue(6, 24, 28, 32, 4, 1'b0, 0);
        n_tests++;
        if (obs_cv !== 16'h0 || obs_any !== 1'b0) begin
            n_fail++; $display("FAIL sub_5m7_carry: got %h any=%b want 0000 any=0", obs_cv, obs_any);
        end
        model_cmd(6, 28, 24, 36, 4);
        issue(6, 28, 24, 36, 4, 1'b0, 0);
        n_tests++;
        if (obs_cv !== 16'hFFFF || obs_all !== 1'b1) begin
            n_fail++; $display("FAIL sub_7m5_carry: got %h all=%b want ffff all=1", obs_cv, obs_all);
        end
        for (int k = 0; k < 4; k++) begin
            host_addr = AW'(32 + k);
            #1;
            n_tests++;
            if (host_rdata !== e1[k]) begin n_fail++; $display("FAIL sub_5m7_plane%0d: got %h want %h", k, host_rdata, e1[k]); end
            host_addr = AW'(36 + k);
            #1;
            n_tests++;
            if (host_rdata !== e2[k]) begin n_fail++; $display("FAIL sub_7m5_plane%0d: got %h want %h", k, host_rdata, e2[k]); end
        end
        tick();
    endtask

    task automatic test_she();
        host_write(40, 16'h8421);
        w_in = 4'b1010;
        model_cmd(9, 40, 40, 41, 1);
        issue(9, 40, 40, 41, 1, 1'b0, 0);
        n_tests++;
        if (obs_e !== 4'b1000 || {obs_n, obs_s, obs_w} !== 12'h0) begin
            n_fail++; $display("FAIL she_edges: got e=%b nsw=%h want e=1000 nsw=000", obs_e, {obs_n, obs_s, obs_w});
        end
        n_tests++;
        if (obs_lat !== 2) begin n_fail++; $display("FAIL she_latency: got %0d want 2", obs_lat); end
        host_addr = AW'(41);
        #1;
        n_tests++;
        if (host_rdata !== 16'h1852) begin n_fail++; $display("FAIL she_result: got %h want 1852", host_rdata); end
        tick();
        w_in = '0;
    endtask

    task automatic test_illegal();
        int nb, fa;
        model_cmd(15, 0, 0, 48, 4);
        issue(15, 0, 0, 48, 4, 1'b0, 0);
        n_tests++;
        if (obs_lat !== 1 || obs_err !== 1'b1) begin
            n_fail++; $display("FAIL illegal_op: got lat=%0d err=%b want lat=1 err=1", obs_lat, obs_err);
        end
        model_cmd(5, 0, 0, 48, 0);
        issue(5, 0, 0, 48, 0, 1'b0, 0);
        n_tests++;
        if (obs_lat !== 1 || obs_err !== 1'b0) begin
            n_fail++; $display("FAIL zero_len: got lat=%0d err=%b want lat=1 err=0", obs_lat, obs_err);
        end
        n_tests++;
        if (obs_cv !== m_carry) begin n_fail++; $display("FAIL zero_len_carry: got %h want %h", obs_cv, m_carry); end
        mem_diff(nb, fa);
        n_tests++;
        if (nb !== 0) begin n_fail++; $display("FAIL illegal_mem: %0d planes differ (first %0d), want 0", nb, fa); end
    endtask

    task automatic test_reset_abort();
        int nb, fa, seen;
        logic [LANES-1:0] saved [DEPTH];
        for (int k = 0; k < 8; k++) host_write(44 + k, ~m_mem[16 + k]);
        saved = m_mem;
        model_cmd(5, 0, 8, 44, 8);
        for (int k = 3; k < 8; k++) m_mem[44 + k] = saved[44 + k];
        m_carry = '0;
        cmd_op = 4'd5; cmd_src_a = AW'(0); cmd_src_b = AW'(8); cmd_dst = AW'(44); cmd_len = 6'd8;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        n_tests++;
        if (cmd_ready !== 1'b1 || carry_vec !== 16'h0) begin
            n_fail++; $display("FAIL abort_ready: got ready=%b cv=%h want 1/0000", cmd_ready, carry_vec);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) seen++;
            tick();
        end
        n_tests++;
        if (seen !== 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses want 0", seen); end
        mem_diff(nb, fa);
        n_tests++;
        if (nb !== 0) begin n_fail++; $display("FAIL abort_mem: %0d planes differ (first %0d), want 0", nb, fa); end
    endtask

    task automatic test_wrap_mov();
        int nb, fa;
        logic [LANES-1:0] v53;
        for (int k = 0; k < 4; k++) host_write(52 + k, 16'($urandom));
        v53 = m_mem[55];
        model_cmd(0, 52, 0, 62, 4);
        issue(0, 52, 0, 62, 4, 1'b1, 10);
        n_tests++;
        if (obs_lat !== 5) begin n_fail++; $display("FAIL wrap_latency: got %0d want 5", obs_lat); end
        host_addr = AW'(1);
        #1;
        n_tests++;
        if (host_rdata !== v53) begin n_fail++; $display("FAIL wrap_plane1: got %h want %h", host_rdata, v53); end
        tick();
        mem_diff(nb, fa);
        n_tests++;
        if (nb !== 0) begin n_fail++; $display("FAIL wrap_mem: %0d planes differ (first %0d), want 0", nb, fa); end
    endtask

    task automatic test_clamp();
        int nb, fa;
        model_cmd(1, 0, 0, 32, 40);
        issue(1, 0, 0, 32, 40, 1'b0, 0);
        n_tests++;
        if (obs_lat !== MAXLEN + 1) begin n_fail++; $display("FAIL clamp_latency: got %0d want %0d", obs_lat, MAXLEN + 1); end
        mem_diff(nb, fa);
        n_tests++;
        if (nb !== 0) begin n_fail++; $display("FAIL clamp_mem: %0d planes differ (first %0d), want 0", nb, fa); end
    endtask

    task automatic test_random();
        int nb, fa, off, op, len, a, b, d;
        for (int it = 0; it < 40; it++) begin
            // Shared offset per command: regions either coincide exactly or are disjoint.
            off = $urandom_range(0, 15);
            a   = ($urandom_range(0, 3) * 16 + off) % DEPTH;
            b   = ($urandom_range(0, 3) * 16 + off) % DEPTH;
            d   = ($urandom_range(0, 3) * 16 + off) % DEPTH;
            op  = $urandom_range(0, 12);
            len = $urandom_range(0, 16);
            n_in = 4'($urandom); s_in = 4'($urandom); e_in = 4'($urandom); w_in = 4'($urandom);
            model_cmd(op, a, b, d, len);
            issue(op, a, b, d, len, 1'b0, 0);
            n_tests++;
            if (obs_lat !== exp_lat || obs_err !== exp_err) begin
                n_fail++; $display("FAIL rnd%0d_done: op=%0d got lat=%0d err=%b want lat=%0d err=%b",
                                   it, op, obs_lat, obs_err, exp_lat, exp_err);
            end
            n_tests++;
            if (obs_cv !== m_carry || obs_all !== (&m_carry) || obs_any !== (|m_carry)) begin
                n_fail++; $display("FAIL rnd%0d_carry: op=%0d got %h want %h", it, op, obs_cv, m_carry);
            end
            n_tests++;
            if ({obs_n, obs_s, obs_e, obs_w} !== {exp_n, exp_s, exp_e, exp_w}) begin
                n_fail++; $display("FAIL rnd%0d_edges: op=%0d got %h want %h", it, op,
                                   {obs_n, obs_s, obs_e, obs_w}, {exp_n, exp_s, exp_e, exp_w});
            end
            mem_diff(nb, fa);
            n_tests++;
            if (nb !== 0) begin
                n_fail++; $display("FAIL rnd%0d_mem: op=%0d %0d planes differ (first %0d), want 0", it, op, nb, fa);
            end
        end
        n_in = '0; s_in = '0; e_in = '0; w_in = '0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_she();
        test_illegal();
        test_reset_abort();
        test_wrap_mov();
        test_clamp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_tile_engine.md
PE_TILE_ENGINE -- requirements
Module: pe_tile_engine

Interface
REQ-001 Parameter TILE, default 4: tile side; LANES = TILE*TILE; lane index = row*TILE+col, with row 0 at the north edge and col 0 at the west edge.
REQ-002 Parameter DEPTH, default 64: bit-plane register file depth; AW = clog2(DEPTH).
REQ-003 Parameter MAXLEN, default 32: maximum operand length in planes.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-low.
REQ-006 cmd_valid  in  1 / cmd_ready  out  1: command handshake.
REQ-007 cmd_op  in  4: opcode. cmd_src_a, cmd_src_b, cmd_dst  in  AW: base plane addresses. cmd_len  in  6: operand length in planes.
REQ-008 done  out  1: one-cycle completion pulse. err  out  1: registered; set when the last completed command was illegal.
REQ-009 carry_vec  out  LANES: per-lane final carry. flag_all / flag_any  out  1: AND / OR of carry_vec.
REQ-010 host_we  in  1, host_addr  in  AW, host_wdata  in  LANES, host_rdata  out  LANES: host plane port.
REQ-011 n_in, s_in, e_in, w_in  in  TILE: neighbour edge inputs.
REQ-012 n_out, s_out, e_out, w_out  out  TILE: edge outputs.

Function
REQ-013 Storage shall be DEPTH planes of LANES bits, one bit per lane; an operand is len consecutive planes, LSB at the base address; all addresses shall wrap modulo DEPTH.
REQ-014 Reads shall be combinational; writes shall occur on the rising edge; host_rdata = plane[host_addr] at all times.
REQ-015 States: IDLE, EXEC, DONE; cmd_ready = 1 only in IDLE.
REQ-016 In IDLE, a host_we write shall be performed; host_we in EXEC or DONE shall be ignored.
REQ-017 On accept (cmd_valid && cmd_ready at an edge), the engine shall latch op, addresses and len, set k = 0, initialise the carry (SUB: 1, all others: 0) and go to EXEC.
REQ-018 A command with len > MAXLEN shall be clamped to MAXLEN.
REQ-019 A command with len = 0, or an opcode > 10, shall go straight to DONE with no writes; err shall be 1 for an opcode > 10 and 0 otherwise.
REQ-020 Each EXEC cycle shall read planes A = src_a+k and B = src_b+k, write the result to dst+k, and increment k; after plane len-1 the engine shall go to DONE.
REQ-021 DONE shall last one cycle, with done = 1, then return to IDLE; done therefore rises len+1 cycles after the accept edge.
REQ-022 Opcodes: 0 MOV A; 1 NOT A; 2 AND; 3 OR; 4 XOR; 5 ADD (A+B+c); 6 SUB (A+~B+c).
REQ-023 ADD and SUB shall be bit-serial per lane, with the carry register updated each plane.
REQ-024 At DONE of ADD/SUB, carry_vec shall take the final carries; for SUB, carry_vec = 1 means A >= B unsigned. Other ops shall leave carry_vec unchanged.
REQ-025 Opcode 7 SHN: result row r = A row r+1; row TILE-1 = s_in; n_out = A row 0.
REQ-026 Opcode 8 SHS: result row r = A row r-1; row 0 = n_in; s_out = A row TILE-1.
REQ-027 Opcode 9 SHE: result col c = A col c-1; col 0 = w_in[row]; e_out[row] = A col TILE-1.
REQ-028 Opcode 10 SHW: result col c = A col c+1; col TILE-1 = e_in[row]; w_out[row] = A col 0.
REQ-029 Edge outputs shall be combinational and driven only by the active shift op in EXEC; they shall be 0 otherwise.
REQ-030 Overlapping src and dst shall behave as sequential plane order: plane k is read before dst+k is written in the same cycle, so in-place operation is exact.
REQ-031 cmd_valid while busy shall be ignored and not queued.

Reset
REQ-032 When reset = 0 at an edge, the engine shall enter IDLE and clear k, the carry, carry_vec and err to 0; done = 0.
REQ-033 Plane contents shall not be cleared by reset.
REQ-034 Reset during EXEC shall abort the command: planes already written are kept, no further writes occur, and no done pulse is produced.
REQ-035 cmd_ready shall be 1 in the first cycle after reset is released.

Verification
REQ-036 TILE=4: host loads planes 0..7 with lane i = i and planes 8..15 = 3; ADD a=0, b=8, dst=16, len=8 -> lane i reads i+3, done 9 cycles after accept, carry_vec = 0.
REQ-037 SUB, all lanes 5 - 7, len=4 -> result 4'hE in every lane, carry_vec = 0, flag_any = 0; repeat with 7 - 5 -> result 2, flag_all = 1.
REQ-038 SHE len=1, plane = 16'h8421, w_in = 4'b1010 -> e_out = 4'b1000 during EXEC, result col 0 = {1,0,1,0} by row, cols shifted east.
REQ-039 ADD len=8 with reset asserted at k=3 -> dst planes 0..2 updated, 3..7 unchanged, no done, cmd_ready = 1 the cycle after release.
REQ-040 Opcode 4'hF and len=0 commands -> done one cycle after accept, no writes; err = 1 for 4'hF and err = 0 for len=0.
REQ-041 MOV with dst=62, len=4 on DEPTH=64 -> writes planes 62, 63, 0, 1; host_we pulsed during EXEC is ignored.
